// File: rtl/fir_mode_ctrl.sv
// rtl/fir_mode_ctrl.sv - FIR mode sequencer: mode change handshake, delay-line flush and settle qualification
//
// Purpose:
//   Owns the mode word of a downstream FIR. A mode change clears the FIR
//   delay line for FLUSH_CYC cycles. Output valid is then withheld until
//   TAPS fresh input samples have been accepted. A request for the mode
//   already in use is acknowledged without disturbing the data path.
//
// Parameters:
//   TAPS      - accepted samples needed after a flush before output is valid
//   FLUSH_CYC - cycles fir_clr is held per flush
//   RST_MODE  - mode applied out of reset
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   1  mode-change request level, held until ack
//   req_mode  in   2  requested mode, stable while req is high
//   din_vld   in   1  FIR input sample accepted this cycle
//   ack       out  1  single-cycle pulse, request taken
//   fir_mode  out  2  registered mode to the FIR
//   fir_clr   out  1  synchronous clear of the FIR delay line
//   dout_vld  out  1  FIR output valid this cycle
//   busy      out  1  high whenever not in RUN

module fir_mode_ctrl #(
    parameter int         TAPS      = 8,
    parameter int         FLUSH_CYC = 2,
    parameter logic [1:0] RST_MODE  = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] req_mode,
    input  logic       din_vld,
    output logic       ack,
    output logic [1:0] fir_mode,
    output logic       fir_clr,
    output logic       dout_vld,
    output logic       busy
);

    localparam int SCNT_W = $clog2(TAPS + 1);
    localparam int FCNT_W = $clog2(FLUSH_CYC + 1);

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(TAPS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [1:0]        fir_mode_q, fir_mode_d;
    logic              ack_q, ack_d;
    logic              fir_clr_q, fir_clr_d;
    logic              dout_vld_q, dout_vld_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        scnt_d     = scnt_q;
        fir_mode_d = fir_mode_q;
        ack_d      = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                // Input samples are deliberately ignored here; the delay
                // line is being cleared so they would be lost anyway.
                if (fcnt_q == FCNT_LAST) begin
                    state_d = ST_SETTLE;
                    fcnt_d  = '0;
                    scnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end

            ST_SETTLE: begin
                // The counter stops at TAPS-1: the sample that would take
                // it to TAPS is the one that releases the FSM into RUN.
                if (din_vld) begin
                    if (scnt_q == SCNT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end

            ST_RUN: begin
                // Gating on ack_q gives the requester one cycle to drop req
                // and keeps ack from ever firing on back-to-back cycles.
                if (req && !ack_q) begin
                    ack_d = 1'b1;
                    if (req_mode != fir_mode_q) begin
                        fir_mode_d = req_mode;
                        state_d    = ST_FLUSH;
                        fcnt_d     = '0;
                    end
                end
            end

            default: begin
                state_d = ST_FLUSH;
                fcnt_d  = '0;
            end
        endcase

        // All flags are derived from the next state so that, once
        // registered, they line up exactly with the state they describe.
        fir_clr_d  = (state_d == ST_FLUSH);
        busy_d     = (state_d != ST_RUN);
        dout_vld_d = (state_d == ST_RUN) && din_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FLUSH;
            fcnt_q     <= '0;
            scnt_q     <= '0;
            fir_mode_q <= RST_MODE;
            ack_q      <= 1'b0;
            fir_clr_q  <= 1'b1;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            scnt_q     <= scnt_d;
            fir_mode_q <= fir_mode_d;
            ack_q      <= ack_d;
            fir_clr_q  <= fir_clr_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign fir_mode = fir_mode_q;
    assign fir_clr  = fir_clr_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fir_mode_ctrl.sv
// tb/tb_fir_mode_ctrl.sv - scoreboard bench for fir_mode_ctrl with directed vectors

module tb_fir_mode_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] req_mode;
    logic       din_vld;
    logic       ack;
    logic [1:0] fir_mode;
    logic       fir_clr;
    logic       dout_vld;
    logic       busy;

    fir_mode_ctrl #(
        .TAPS      (8),
        .FLUSH_CYC (2),
        .RST_MODE  (2'd3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_mode (req_mode),
        .din_vld  (din_vld),
        .ack      (ack),
        .fir_mode (fir_mode),
        .fir_clr  (fir_clr),
        .dout_vld (dout_vld),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ack;
        logic [1:0] mode;
        logic       clr;
        logic       dv;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    // Monitor: every cycle that has an expectation queued is checked here.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  got;
        string t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = '{ack: ack, mode: fir_mode, clr: fir_clr, dv: dout_vld, busy: busy};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got ack=%b mode=%0d clr=%b dv=%b busy=%b exp ack=%b mode=%0d clr=%b dv=%b busy=%b",
                         t, cyc, got.ack, got.mode, got.clr, got.dv, got.busy,
                         e.ack, e.mode, e.clr, e.dv, e.busy);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected to be visible during that cycle.
    task automatic step(input logic rst, input logic rq, input logic [1:0] rm, input logic dv_in,
                        input logic e_ack, input logic [1:0] e_mode, input logic e_clr,
                        input logic e_dv, input logic e_busy, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst_n    = rst;
        req      = rq;
        req_mode = rm;
        din_vld  = dv_in;
        e = '{ack: e_ack, mode: e_mode, clr: e_clr, dv: e_dv, busy: e_busy};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 1'b0;
        req_mode = 2'd0;
        din_vld  = 1'b0;

        // Held in reset
        for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 1, 0, 2'd3, 1, 0, 1, "reset");

        // Bring-up with din_vld every cycle: clr cycles 1-2, busy 1-10, dv from 11
        for (int k = 1; k <= 14; k++)
            step(1, 0, 2'd0, 1, 0, 2'd3, k <= 2, k >= 11, k <= 10, "bringup");

        // RUN: dout_vld follows din_vld one cycle late
        step(1, 0, 2'd0, 0, 0, 2'd3, 0, 1, 0, "run_dv0");
        step(1, 0, 2'd0, 1, 0, 2'd3, 0, 0, 0, "run_dv1");
        step(1, 0, 2'd0, 0, 0, 2'd3, 0, 1, 0, "run_dv2");
        step(1, 0, 2'd0, 1, 0, 2'd3, 0, 0, 0, "run_dv3");
        step(1, 0, 2'd0, 1, 0, 2'd3, 0, 1, 0, "run_dv4");

        // Same-mode request: one ack, req held one more cycle is ignored
        step(1, 1, 2'd3, 1, 0, 2'd3, 0, 1, 0, "same_req");
        step(1, 1, 2'd3, 1, 1, 2'd3, 0, 1, 0, "same_ack");
        step(1, 0, 2'd0, 1, 0, 2'd3, 0, 1, 0, "same_after");
        step(1, 0, 2'd0, 1, 0, 2'd3, 0, 1, 0, "same_after2");

        // Mode change to 2: ack and new mode together, 2-cycle flush, 8-sample settle
        step(1, 1, 2'd2, 1, 0, 2'd3, 0, 1, 0, "chg_req");
        step(1, 1, 2'd2, 1, 1, 2'd2, 1, 0, 1, "chg_ack");
        step(1, 0, 2'd0, 1, 0, 2'd2, 1, 0, 1, "chg_flush2");
        for (int k = 0; k < 8; k++) step(1, 0, 2'd0, 1, 0, 2'd2, 0, 0, 1, "chg_settle");
        step(1, 0, 2'd0, 1, 0, 2'd2, 0, 1, 0, "chg_run");
        step(1, 0, 2'd0, 1, 0, 2'd2, 0, 1, 0, "chg_run2");

        // Change to 0, din during flush not counted, toggling din in settle,
        // req for mode 1 raised mid-settle and served on RUN entry
        step(1, 1, 2'd0, 1, 0, 2'd2, 0, 1, 0, "tog_req");
        step(1, 1, 2'd0, 1, 1, 2'd0, 1, 0, 1, "tog_ack");
        step(1, 0, 2'd0, 1, 0, 2'd0, 1, 0, 1, "tog_flush2");
        for (int j = 0; j < 15; j++)
            step(1, j >= 3, 2'd1, (j % 2) == 0, 0, 2'd0, 0, 0, 1, "tog_settle");
        step(1, 1, 2'd1, 0, 0, 2'd0, 0, 1, 0, "tog_run");
        step(1, 1, 2'd1, 1, 1, 2'd1, 1, 0, 1, "pend_ack");
        step(1, 0, 2'd0, 1, 0, 2'd1, 1, 0, 1, "pend_flush2");

        // Reset pulse in the 4th settle cycle, then a full restart in mode 3
        for (int k = 0; k < 3; k++) step(1, 0, 2'd0, 1, 0, 2'd1, 0, 0, 1, "rst_settle");
        step(0, 0, 2'd0, 1, 0, 2'd3, 1, 0, 1, "rst_async");
        for (int k = 1; k <= 12; k++)
            step(1, 0, 2'd0, 1, 0, 2'd3, k <= 2, k >= 11, k <= 10, "rebringup");

        // Reset lands on the ack cycle: ack wiped, held req served only after a new settle
        step(1, 1, 2'd0, 1, 0, 2'd3, 0, 1, 0, "ackrst_req");
        step(0, 1, 2'd0, 1, 0, 2'd3, 1, 0, 1, "ackrst_rst");
        for (int k = 1; k <= 10; k++)
            step(1, 1, 2'd0, 1, 0, 2'd3, k <= 2, 0, 1, "ackrst_rebring");
        step(1, 1, 2'd0, 1, 0, 2'd3, 0, 1, 0, "ackrst_run");
        step(1, 0, 2'd0, 1, 1, 2'd0, 1, 0, 1, "ackrst_ack");
        step(1, 0, 2'd0, 1, 0, 2'd0, 1, 0, 1, "ackrst_flush2");

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
